// File: rtl/counter_enable_gen.sv
// counter_enable_gen
//
// Programmable enable-pulse generator for the downstream 4-bit count stage.
// An accepted start emits a single-cycle enable pulse immediately, then one
// pulse every max(period,1) clocks, either for burst_len pulses (then a
// one-cycle done strobe) or continuously (burst_len = 0) until stop.
//
// Parameters:
//   PERIOD_WIDTH - width of period and the internal prescaler
//   BURST_WIDTH  - width of burst_len and pulse_count
//
// Ports:
//   clk         in  rising-edge clock
//   reset       in  synchronous active-high reset, highest priority
//   start       in  begin a run (accepted in IDLE or DONE when stop is low)
//   stop        in  abort a run; also vetoes a simultaneous start
//   period      in  clocks between pulses, latched on accepted start
//   burst_len   in  pulses per run, 0 = continuous, latched on accepted start
//   enable      out one-cycle pulse to the downstream counter
//   busy        out high while running
//   done        out one-cycle strobe after a burst completes normally
//   pulse_count out pulses issued in the current or last run (wraps)
//
// All outputs are registered.

module counter_enable_gen #(
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned BURST_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [BURST_WIDTH-1:0]  burst_len,
    output logic                    enable,
    output logic                    busy,
    output logic                    done,
    output logic [BURST_WIDTH-1:0]  pulse_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [BURST_WIDTH-1:0]  burst_q;
    logic [PERIOD_WIDTH-1:0] presc;
    logic [PERIOD_WIDTH-1:0] period_eff;
    logic                    pulse_due;
    logic                    burst_end;

    // A period of 0 behaves like 1: a pulse every cycle.
    always_comb begin
        period_eff = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;
        pulse_due  = (presc >= period_eff);
        // The last pulse of a burst has already been issued; leave RUN now.
        burst_end  = (burst_q != '0) && (pulse_count == burst_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            period_q    <= '0;
            burst_q     <= '0;
            presc       <= '0;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_count <= '0;
        end else begin
            case (state)
                // DONE accepts start exactly like IDLE so back-to-back runs
                // have no dead cycle.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start && !stop) begin
                        state       <= RUN;
                        period_q    <= period;
                        burst_q     <= burst_len;
                        presc       <= PERIOD_WIDTH'(1);
                        enable      <= 1'b1;
                        busy        <= 1'b1;
                        pulse_count <= BURST_WIDTH'(1);
                    end else begin
                        state  <= IDLE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                    end
                end

                RUN: begin
                    if (stop) begin
                        // Abort: suppresses any pulse due this cycle, count holds.
                        state  <= IDLE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                    end else if (burst_end) begin
                        state  <= DONE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (pulse_due) begin
                        presc       <= PERIOD_WIDTH'(1);
                        enable      <= 1'b1;
                        pulse_count <= pulse_count + BURST_WIDTH'(1);
                    end else begin
                        presc  <= presc + PERIOD_WIDTH'(1);
                        enable <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_enable_gen.sv
// Testbench for counter_enable_gen (BURST_WIDTH = 4 so pulse_count wraps
// quickly). A run-level reference model predicts the outputs after every
// clock edge from the elapsed cycles since the accepted start; predictions
// are queued and a separate monitor compares them with the DUT.

module tb_counter_enable_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = '0;
    logic [3:0]  burst_len = '0;
    logic        enable;
    logic        busy;
    logic        done;
    logic [3:0]  pulse_count;

    counter_enable_gen #(
        .PERIOD_WIDTH(16),
        .BURST_WIDTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .period     (period),
        .burst_len  (burst_len),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       edge_no;
        logic     en;
        logic     bz;
        logic     dn;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference model state: 0 = idle, 1 = running, 2 = burst just finished
    int     mstate = 0;
    longint e = 0;
    longint start_e = 0;
    longint pe = 1;
    longint bl = 0;
    logic       m_en = 1'b0;
    logic       m_bz = 1'b0;
    logic       m_dn = 1'b0;
    logic [3:0] m_cnt = '0;

    // Predict outputs after the coming edge from the inputs presented to it.
    task automatic model(input logic r, input logic s, input logic sp,
                         input logic [15:0] p, input logic [3:0] b);
        longint k;
        if (r) begin
            mstate = 0; m_en = 0; m_bz = 0; m_dn = 0; m_cnt = '0;
        end else if (mstate != 1) begin
            m_dn = 0;
            if (s && !sp) begin
                mstate = 1; start_e = e;
                pe = (p == 0) ? 1 : longint'(p);
                bl = longint'(b);
                m_en = 1; m_bz = 1; m_cnt = 4'd1;
            end else begin
                mstate = 0; m_en = 0; m_bz = 0;
            end
        end else begin
            k = e - start_e;
            if (sp) begin
                mstate = 0; m_en = 0; m_bz = 0; m_dn = 0;
            end else if (bl != 0 && ((k - 1) / pe + 1) == bl) begin
                mstate = 2; m_en = 0; m_bz = 0; m_dn = 1;
            end else begin
                m_en  = ((k % pe) == 0);
                m_bz  = 1; m_dn = 0;
                m_cnt = 4'((k / pe + 1) % 16);
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic sp,
                        input logic [15:0] p, input logic [3:0] b);
        exp_t x;
        @(negedge clk);
        reset = r; start = s; stop = sp; period = p; burst_len = b;
        model(r, s, sp, p, b);
        x.edge_no = int'(e);
        x.en = m_en; x.bz = m_bz; x.dn = m_dn; x.cnt = m_cnt;
        q.push_back(x);
        e++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'($urandom_range(0, 9)), 4'($urandom));
    endtask

    // Monitor: outputs are registered, so every edge presents a new sample.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                compared++;
                if (enable !== x.en || busy !== x.bz || done !== x.dn || pulse_count !== x.cnt) begin
                    mismatched++;
                    $display("FAIL outputs edge %0d: got en=%b busy=%b done=%b cnt=%0d, expected en=%b busy=%b done=%b cnt=%0d",
                             x.edge_no, enable, busy, done, pulse_count, x.en, x.bz, x.dn, x.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset, then a quiet idle stretch
        step(1, 0, 0, 16'd0, 4'd0);
        idle(10);

        // period 4, burst 3
        step(0, 1, 0, 16'd4, 4'd3);
        idle(12);

        // period 0, burst 5: five back-to-back pulses
        step(0, 1, 0, 16'd0, 4'd5);
        idle(8);

        // Continuous, period 1: wraps 15 -> 0, then stop
        step(0, 1, 0, 16'd1, 4'd0);
        idle(20);
        step(0, 0, 1, 16'd1, 4'd0);
        idle(4);

        // start + stop together in IDLE
        step(0, 1, 1, 16'd2, 4'd2);
        idle(3);

        // Run with period 3, re-start with period 1 mid-run (ignored),
        // then restart in the DONE cycle
        step(0, 1, 0, 16'd3, 4'd4);
        idle(2);
        step(0, 1, 0, 16'd1, 4'd9);
        guard = 0;
        while (mstate != 2 && guard < 100) begin
            step(0, 0, 0, 16'd1, 4'd9);
            guard++;
        end
        step(0, 1, 0, 16'd2, 4'd2);
        idle(8);

        // Reset mid-burst after two pulses, then a fresh identical run
        step(0, 1, 0, 16'd3, 4'd5);
        idle(4);
        step(1, 0, 0, 16'd3, 4'd5);
        idle(2);
        step(0, 1, 0, 16'd3, 4'd5);
        idle(16);

        // Stop on a cycle where a pulse is due
        step(0, 1, 0, 16'd2, 4'd0);
        idle(1);
        step(0, 0, 1, 16'd2, 4'd0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 5),
                 16'($urandom_range(0, 5)),
                 4'($urandom_range(0, 6)));
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
